rc4_keystream_gen: RTL

RC4 keystream responder for the RC4 decryption core. On request it runs the key-scheduling algorithm (KSA) over a 256-byte state array using a supplied key. It then returns one pseudo-random keystream byte per request (PRGA) for the core to XOR with pixel data. It answers the core's genStateArr/sarrGenerated and genVal/valReady handshakes and owns the full S-box, i/j pointers and key.

---
 rtl/rc4_keystream_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rc4_keystream_gen.sv
// rtl/rc4_keystream_gen.sv - RC4 state-array scheduler and keystream byte generator
// Builds S with KSA on genStateArr_i, then returns one PRGA byte per genVal_i request.
module rc4_keystream_gen #(
  parameter int KEY_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   n_rst_i,
  input  logic                   genStateArr_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  logic                   genVal_i,
  output logic                   sarrGenerated_o,
  output logic                   valReady_o,
  output logic [7:0]             outputToXor_o
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA,
    READY,
    PRGA_STEP,
    PRGA_OUT
  } state_t;

  state_t       r_state;
  logic [7:0]   r_s [256];
  logic [255:0] r_key;
  logic [7:0]   r_i;
  logic [7:0]   r_j;
  logic [4:0]   r_kx;
  logic         r_sarr;
  logic         r_val_ready;
  logic [7:0]   r_out;

  logic [7:0]   w_key_byte;
  logic [7:0]   w_i_next;
  logic [7:0]   w_idx_a;
  logic [7:0]   w_s_a;
  logic [7:0]   w_j_new;
  logic [7:0]   w_s_b;
  logic [7:0]   w_out_idx;
  logic         w_swap;

  // KSA swaps at S[i]; PRGA_STEP swaps at S[i+1]. Both share one swap datapath.
  assign w_key_byte = r_key[{r_kx, 3'b000} +: 8];
  assign w_i_next   = r_i + 8'd1;
  assign w_idx_a    = (r_state == PRGA_STEP) ? w_i_next : r_i;
  assign w_s_a      = r_s[w_idx_a];
  assign w_j_new    = r_j + w_s_a + ((r_state == KSA) ? w_key_byte : 8'd0);
  assign w_s_b      = r_s[w_j_new];
  assign w_out_idx  = r_s[r_i] + r_s[r_j];
  assign w_swap     = (r_state == KSA) || (r_state == PRGA_STEP);

  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      for (int k = 0; k < 256; k++) begin
        r_s[k] <= 8'(k);
      end
    end else if (w_swap) begin
      r_s[w_idx_a] <= w_s_b;
      r_s[w_j_new] <= w_s_a;
    end
  end

  always_ff @(posedge clk) begin
    if (genStateArr_i) begin
      r_key <= 256'(key_i);
    end
  end

  always_ff @(posedge clk or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state     <= IDLE;
      r_i         <= 8'd0;
      r_j         <= 8'd0;
      r_kx        <= 5'd0;
      r_sarr      <= 1'b0;
      r_val_ready <= 1'b0;
      r_out       <= 8'd0;
    end else begin
      r_val_ready <= 1'b0;
      if (genStateArr_i) begin
        r_state <= INIT;
        r_sarr  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          INIT: begin
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_kx    <= 5'd0;
            r_state <= KSA;
          end
          KSA: begin
            r_kx <= (r_kx == 5'(KEY_BYTES - 1)) ? 5'd0 : r_kx + 5'd1;
            if (r_i == 8'hFF) begin
              r_i     <= 8'd0;
              r_j     <= 8'd0;
              r_sarr  <= 1'b1;
              r_state <= READY;
            end else begin
              r_i <= w_i_next;
              r_j <= w_j_new;
            end
          end
          READY: begin
            if (genVal_i) begin
              r_state <= PRGA_STEP;
            end
          end
          PRGA_STEP: begin
            r_i     <= w_i_next;
            r_j     <= w_j_new;
            r_state <= PRGA_OUT;
          end
          PRGA_OUT: begin
            r_out       <= r_s[w_out_idx];
            r_val_ready <= 1'b1;
            r_state     <= READY;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sarrGenerated_o = r_sarr;
  assign valReady_o      = r_val_ready;
  assign outputToXor_o   = r_out;

endmodule
